ps2_kbd_rx: RTL



---
 rtl/kbd_pkg.sv | 16 +
 rtl/ps2_sync.sv | 35 +++
 rtl/ps2_kbd_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared types and PS/2 frame constants for the keyboard receiver.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int         PS2_DATA_BITS  = 8;
  localparam logic       PS2_START_BIT  = 1'b0;
  localparam logic       PS2_STOP_BIT   = 1'b1;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_sync.sv
// Synchronises the raw PS/2 clock/data pins into the core domain and flags
// PS/2 clock falling edges, registered so data_s and clk_fall stay aligned.
module ps2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_q;

  // Lines idle high, so every synchroniser flop resets to 1 to avoid a false edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_q     <= 1'b1;
      data_s    <= 1'b1;
      clk_fall  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_q     <= clk_sync[SYNC_STAGES-1];
      clk_fall  <= clk_q & ~clk_sync[SYNC_STAGES-1];
      data_s    <= data_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver feeding the register file's keyboard port.
// Optional BREAK_FILTER_EN suppresses F0 break codes and the released key's code.
module ps2_kbd_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] gpi,
  output logic       gpi_we,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic                     data_s;
  logic                     clk_fall;
  state_t                   state, state_n;
  logic [2:0]               bit_cnt, bit_cnt_n;
  logic [PS2_DATA_BITS-1:0] shift_reg, shift_n;
  logic                     parity_bit, parity_n;
  logic [CNT_W-1:0]         to_cnt, to_cnt_n;
  logic [7:0]               gpi_n;
  logic                     gpi_we_n, frame_err_n;
  logic                     timed_out;
  logic                     frame_ok;
`ifdef BREAK_FILTER_EN
  logic                     break_pending, break_n;
`endif

  ps2_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      gpi        <= 8'h00;
      gpi_we     <= 1'b0;
      frame_err  <= 1'b0;
`ifdef BREAK_FILTER_EN
      break_pending <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_n;
      parity_bit <= parity_n;
      to_cnt     <= to_cnt_n;
      gpi        <= gpi_n;
      gpi_we     <= gpi_we_n;
      frame_err  <= frame_err_n;
`ifdef BREAK_FILTER_EN
      break_pending <= break_n;
`endif
    end
  end

  // A falling edge always takes priority over the timeout in the same cycle.
  assign timed_out = (state != IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign frame_ok  = (data_s == PS2_STOP_BIT) && (^{shift_reg, parity_bit});

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_reg;
    parity_n    = parity_bit;
    gpi_n       = gpi;
    gpi_we_n    = 1'b0;
    frame_err_n = 1'b0;
`ifdef BREAK_FILTER_EN
    break_n     = break_pending;
`endif
    to_cnt_n    = (clk_fall || state == IDLE || timed_out) ? '0 : to_cnt + 1'b1;

    if (clk_fall) begin
      case (state)
        IDLE: begin
          if (data_s == PS2_START_BIT) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shift_n   = {data_s, shift_reg[PS2_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = PARITY;
        end
        PARITY: begin
          parity_n = data_s;
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (frame_ok) begin
`ifdef BREAK_FILTER_EN
            if (shift_reg == PS2_BREAK_CODE) begin
              break_n = 1'b1;
            end else if (break_pending) begin
              break_n = 1'b0;
            end else begin
              gpi_n    = shift_reg;
              gpi_we_n = 1'b1;
            end
`else
            gpi_n    = shift_reg;
            gpi_we_n = 1'b1;
`endif
          end else begin
            frame_err_n = 1'b1;
`ifdef BREAK_FILTER_EN
            break_n     = 1'b0;
`endif
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (timed_out) begin
      state_n     = IDLE;
      shift_n     = '0;
      frame_err_n = 1'b1;
`ifdef BREAK_FILTER_EN
      break_n     = 1'b0;
`endif
    end
  end

endmodule
